// File: rtl/operand_sequencer.sv
// Operand sequencer: collects A, B and opcode bytes from the entry unit, executes, and holds a 16-bit result.
// Optional macro OPSEQ_CHAIN_EN: start in SHOW reuses the low result byte as operand A and skips to GET_B.
module operand_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     value,
    input  logic                  value_ready,
    output logic                  in_enable,
    output logic [1:0]            stage,
    output logic                  busy,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_valid,
    output logic                  error
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_OP, EXEC, SHOW} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, op_q, op_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                error_q, error_d;

    logic [2:0]          op_sel;
    logic                op_bad, is_div, b_zero, div_iter, last_iter;
    logic [DATA_W:0]     shifted, diff;
    logic                fits;
    logic [DATA_W-1:0]   rem_nx, quo_nx;
    logic [RES_W-1:0]    ae, be, quick_res;
    logic                quick_err;

    assign op_sel    = op_q[2:0];
    assign op_bad    = |op_q[DATA_W-1:3];
    assign is_div    = (op_sel == 3'd6) || (op_sel == 3'd7);
    assign b_zero    = (b_q == '0);
    assign div_iter  = is_div && !op_bad && !b_zero;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    // One restoring step: shift next dividend bit into the remainder, subtract B if it fits.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign fits    = ~diff[DATA_W];
    assign rem_nx  = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_nx  = {quo_q[DATA_W-2:0], fits};

    assign ae = {{DATA_W{1'b0}}, a_q};
    assign be = {{DATA_W{1'b0}}, b_q};

    always_comb begin
        quick_res = '0;
        quick_err = 1'b0;
        if (op_bad) begin
            quick_err = 1'b1;
        end else begin
            case (op_sel)
                3'd0:    quick_res = ae + be;
                3'd1:    quick_res = ae - be;
                3'd2:    quick_res = ae * be;
                3'd3:    quick_res = ae & be;
                3'd4:    quick_res = ae | be;
                3'd5:    quick_res = ae ^ be;
                default: begin
                    quick_res = '1;
                    quick_err = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = GET_A;
                GET_A:   if (value_ready) state_d = GET_B;
                GET_B:   if (value_ready) state_d = GET_OP;
                GET_OP:  if (value_ready) state_d = EXEC;
                EXEC:    if (!div_iter || last_iter) state_d = SHOW;
                SHOW: begin
`ifdef OPSEQ_CHAIN_EN
                    if (start) state_d = GET_B;
`else
                    if (start) state_d = GET_A;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_enable    = 1'b0;
        stage        = 2'd0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            GET_A:  begin in_enable = 1'b1; stage = 2'd1; end
            GET_B:  begin in_enable = 1'b1; stage = 2'd2; end
            GET_OP: begin in_enable = 1'b1; stage = 2'd3; end
            EXEC:   busy = 1'b1;
            SHOW:   result_valid = 1'b1;
            default: ;
        endcase
        result = result_q;
        error  = error_q;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        if (clear) begin
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            rem_d    = '0;
            quo_d    = '0;
            cnt_d    = '0;
            result_d = '0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                GET_A:  if (value_ready) a_d = value;
                GET_B:  if (value_ready) b_d = value;
                GET_OP: if (value_ready) begin
                    op_d  = value;
                    rem_d = '0;
                    quo_d = a_q;
                    cnt_d = '0;
                end
                EXEC: begin
                    if (div_iter) begin
                        rem_d = rem_nx;
                        quo_d = quo_nx;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            result_d = (op_sel == 3'd6) ? {rem_nx, quo_nx}
                                                        : {{DATA_W{1'b0}}, rem_nx};
                            error_d  = 1'b0;
                        end
                    end else begin
                        result_d = quick_res;
                        error_d  = quick_err;
                    end
                end
                SHOW: if (start) begin
                    error_d = 1'b0;
`ifdef OPSEQ_CHAIN_EN
                    a_d     = result_q[DATA_W-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed self-checking bench for operand_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_operand_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  value = '0;
    logic        value_ready = 1'b0;
    logic        in_enable;
    logic [1:0]  stage;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        error;

    int checks = 0;
    int errors = 0;

    operand_sequencer #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .value(value), .value_ready(value_ready), .in_enable(in_enable),
        .stage(stage), .busy(busy), .result(result),
        .result_valid(result_valid), .error(error)
    );

    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk); value = v; value_ready = 1'b1;
        @(negedge clk); value_ready = 1'b0;
    endtask

    // Runs one full operation from IDLE; bc = cycles with busy high, -1 if result never appeared.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, output int bc);
        pulse_clear();
        pulse_start();
        send_byte(a);
        send_byte(b);
        send_byte(op);
        bc = 0;
        for (int i = 0; i < 40 && !result_valid; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        if (!result_valid) bc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({in_enable, stage, busy, result, result_valid, error} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {in_enable, stage, busy, result, result_valid, error});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        pulse_start();
        checks++;
        if ({in_enable, stage} !== 3'b1_01) begin errors++; $display("FAIL add_getA got %b exp 101", {in_enable, stage}); end
        send_byte(8'h2F);
        checks++;
        if ({in_enable, stage} !== 3'b1_10) begin errors++; $display("FAIL add_getB got %b exp 110", {in_enable, stage}); end
        send_byte(8'h11);
        checks++;
        if ({in_enable, stage} !== 3'b1_11) begin errors++; $display("FAIL add_getOP got %b exp 111", {in_enable, stage}); end
        send_byte(8'h00);
        checks++;
        if ({busy, in_enable, stage, result_valid} !== 5'b1_0_00_0) begin
            errors++; $display("FAIL add_exec got %b exp 10000", {busy, in_enable, stage, result_valid});
        end
        @(negedge clk);
        checks++;
        if ({busy, result_valid, error, result} !== {3'b010, 16'h0040}) begin
            errors++; $display("FAIL add_result got %h exp %h", {busy, result_valid, error, result}, {3'b010, 16'h0040});
        end
    endtask

    task automatic test_arith();
        int bc;
        logic [7:0]  av [6] = '{8'h03, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'h80};
        logic [7:0]  bv [6] = '{8'h05, 8'hFF, 8'h3C, 8'h3C, 8'h3C, 8'h90};
        logic [7:0]  ov [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        logic [15:0] ev [6] = '{16'hFFFE, 16'hFE01, 16'h0030, 16'h00FC, 16'h00CC, 16'h0110};
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], bv[i], ov[i], bc);
            checks++;
            if (result !== ev[i] || error !== 1'b0 || bc !== 1) begin
                errors++;
                $display("FAIL arith_%0d got res=%h err=%b busy=%0d exp res=%h err=0 busy=1", i, result, error, bc, ev[i]);
            end
        end
    endtask

    task automatic test_div();
        int bc;
        run_op(8'd200, 8'd7, 8'h06, bc);
        checks++;
        if (result !== 16'h041C || error !== 1'b0 || bc !== 8) begin
            errors++; $display("FAIL div got res=%h err=%b busy=%0d exp res=041c err=0 busy=8", result, error, bc);
        end
        run_op(8'd200, 8'd7, 8'h07, bc);
        checks++;
        if (result !== 16'h0004 || error !== 1'b0 || bc !== 8) begin
            errors++; $display("FAIL mod got res=%h err=%b busy=%0d exp res=0004 err=0 busy=8", result, error, bc);
        end
        run_op(8'hFF, 8'h01, 8'h06, bc);
        checks++;
        if (result !== 16'h00FF || bc !== 8) begin
            errors++; $display("FAIL div_by1 got res=%h busy=%0d exp res=00ff busy=8", result, bc);
        end
    endtask

    task automatic test_errors();
        int bc;
        run_op(8'd9, 8'd0, 8'h09, bc);
        checks++;
        if (result !== 16'h0000 || error !== 1'b1 || bc !== 1) begin
            errors++; $display("FAIL bad_opcode got res=%h err=%b busy=%0d exp res=0000 err=1 busy=1", result, error, bc);
        end
        run_op(8'd9, 8'd0, 8'h06, bc);
        checks++;
        if (result !== 16'hFFFF || error !== 1'b1 || bc !== 1) begin
            errors++; $display("FAIL div_zero got res=%h err=%b busy=%0d exp res=ffff err=1 busy=1", result, error, bc);
        end
    endtask

    // Follows test_errors: SHOW holds the divide-by-zero result.
    task automatic test_show_restart();
        send_byte(8'h55);
        checks++;
        if ({result_valid, stage, error, result} !== {1'b1, 2'd0, 1'b1, 16'hFFFF}) begin
            errors++; $display("FAIL show_vr_ignored got %h exp %h", {result_valid, stage, error, result}, {1'b1, 2'd0, 1'b1, 16'hFFFF});
        end
        pulse_start();
        checks++;
`ifdef OPSEQ_CHAIN_EN
        if ({result_valid, error, stage, in_enable, result} !== {1'b0, 1'b0, 2'd2, 1'b1, 16'hFFFF}) begin
            errors++; $display("FAIL show_restart got %h exp %h", {result_valid, error, stage, in_enable, result}, {1'b0, 1'b0, 2'd2, 1'b1, 16'hFFFF});
        end
`else
        if ({result_valid, error, stage, in_enable, result} !== {1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFF}) begin
            errors++; $display("FAIL show_restart got %h exp %h", {result_valid, error, stage, in_enable, result}, {1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFF});
        end
`endif
    endtask

    task automatic test_clear();
        pulse_clear();
        send_byte(8'h12);
        checks++;
        if ({stage, in_enable, result_valid} !== 4'b0) begin
            errors++; $display("FAIL idle_vr_ignored got %b exp 0000", {stage, in_enable, result_valid});
        end
        pulse_start();
        send_byte(8'h12);
        checks++;
        if (stage !== 2'd2) begin errors++; $display("FAIL clear_pre got %0d exp 2", stage); end
        pulse_clear();
        checks++;
        if ({stage, in_enable, result, error} !== 20'd0) begin
            errors++; $display("FAIL clear_getB got %h exp 0", {stage, in_enable, result, error});
        end
    endtask

    task automatic test_exec_start();
        int bc;
        pulse_clear();
        pulse_start();
        send_byte(8'd200);
        send_byte(8'd7);
        send_byte(8'h06);
        bc = 0;
        for (int i = 0; i < 40 && !result_valid; i++) begin
            if (busy) bc++;
            start = (i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (bc !== 8 || result !== 16'h041C || stage !== 2'd0 || result_valid !== 1'b1) begin
            errors++; $display("FAIL exec_start_ignored got busy=%0d res=%h stage=%0d rv=%b exp busy=8 res=041c stage=0 rv=1", bc, result, stage, result_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        int bc;
        pulse_clear();
        pulse_start();
        send_byte(8'd200);
        send_byte(8'd7);
        send_byte(8'h06);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_div_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_enable, stage, busy, result, result_valid, error} !== 21'd0) begin
            errors++; $display("FAIL mid_div_reset got %h exp 0", {in_enable, stage, busy, result, result_valid, error});
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(8'd200, 8'd7, 8'h07, bc);
        checks++;
        if (result !== 16'h0004 || bc !== 8) begin
            errors++; $display("FAIL post_reset_mod got res=%h busy=%0d exp res=0004 busy=8", result, bc);
        end
    endtask

    task automatic test_chain();
        int bc;
        run_op(8'h2F, 8'h11, 8'h00, bc);
        checks++;
        if (result !== 16'h0040) begin errors++; $display("FAIL chain_seed got %h exp 0040", result); end
        pulse_start();
`ifdef OPSEQ_CHAIN_EN
        checks++;
        if ({stage, in_enable} !== 3'b10_1) begin errors++; $display("FAIL chain_stage got %b exp 101", {stage, in_enable}); end
        send_byte(8'h02);
        send_byte(8'h02);
        @(negedge clk);
        checks++;
        if (result !== 16'h0080 || result_valid !== 1'b1) begin
            errors++; $display("FAIL chain_result got res=%h rv=%b exp res=0080 rv=1", result, result_valid);
        end
`else
        checks++;
        if ({stage, in_enable} !== 3'b01_1) begin errors++; $display("FAIL chain_stage got %b exp 011", {stage, in_enable}); end
        send_byte(8'h02);
        send_byte(8'h02);
        checks++;
        if (stage !== 2'd3 || result_valid !== 1'b0) begin
            errors++; $display("FAIL nochain_getop got stage=%0d rv=%b exp stage=3 rv=0", stage, result_valid);
        end
        send_byte(8'h00);
        @(negedge clk);
        checks++;
        if (result !== 16'h0004 || result_valid !== 1'b1) begin
            errors++; $display("FAIL nochain_result got res=%h rv=%b exp res=0004 rv=1", result, result_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith();
        test_div();
        test_errors();
        test_show_restart();
        test_clear();
        test_exec_start();
        test_reset_mid_div();
        test_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
